// File: rtl/pwm_gen.sv
// pwm_gen: four-channel fixed-duty PWM sharing one free-running period counter
module pwm_gen #(
    parameter int PERIOD = 16,
    parameter int DUTY0  = 4,
    parameter int DUTY1  = 8,
    parameter int DUTY2  = 12,
    parameter int DUTY3  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] pwm_out
);
    localparam int CNT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    // one extra bit so a duty equal to PERIOD stays representable
    localparam logic [CNT_W:0] D0 = (CNT_W+1)'(DUTY0);
    localparam logic [CNT_W:0] D1 = (CNT_W+1)'(DUTY1);
    localparam logic [CNT_W:0] D2 = (CNT_W+1)'(DUTY2);
    localparam logic [CNT_W:0] D3 = (CNT_W+1)'(DUTY3);

    if (PERIOD < 2 || PERIOD > 65536) begin : g_bad_period
        $error("pwm_gen: PERIOD %0d outside 2..65536", PERIOD);
    end
    if (DUTY0 < 0 || DUTY0 > PERIOD || DUTY1 < 0 || DUTY1 > PERIOD ||
        DUTY2 < 0 || DUTY2 > PERIOD || DUTY3 < 0 || DUTY3 > PERIOD) begin : g_bad_duty
        $error("pwm_gen: every DUTY must lie in 0..PERIOD (%0d)", PERIOD);
    end

    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   cnt_x;
    logic [3:0]       hi;

    assign cnt_x = {1'b0, cnt};
    assign hi    = {cnt_x < D3, cnt_x < D2, cnt_x < D1, cnt_x < D0};

    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt     <= '0;
            pwm_out <= '0;
        end else begin
            cnt     <= (cnt == LAST) ? '0 : cnt + 1'b1;
            pwm_out <= hi;
        end
    end
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: random-reset stimulus against a period/phase arithmetic model
module tb_pwm_gen;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] pwm_a, pwm_b;
    int         n_tests = 0;
    int         n_fail = 0;
    int         m = 0;
    int         hi_a [4];
    int         hi_b [4];

    localparam int PA = 16;
    localparam int PB = 10;
    localparam int DA [4] = '{4, 8, 12, 16};
    localparam int DB [4] = '{0, 3, 7, 10};

    always #5 clk = ~clk;

    pwm_gen dut_a (.clk(clk), .rst_n(rst_n), .pwm_out(pwm_a));
    pwm_gen #(.PERIOD(PB), .DUTY0(DB[0]), .DUTY1(DB[1]), .DUTY2(DB[2]), .DUTY3(DB[3]))
        dut_b (.clk(clk), .rst_n(rst_n), .pwm_out(pwm_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input int run, input int p, input int d [4]);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (run % p) < d[i];
        return v;
    endfunction

    // m counts run edges since the last reset edge
    task automatic step(input logic r);
        logic [3:0] ea, eb;
        @(negedge clk) rst_n = r;
        @(posedge clk);
        #1;
        if (r) begin
            ea = 4'b0;
            eb = 4'b0;
            m = 0;
        end else begin
            ea = model(m, PA, DA);
            eb = model(m, PB, DB);
            m++;
        end
        check("pwm_a", 32'(pwm_a), 32'(ea));
        check("pwm_b", 32'(pwm_b), 32'(eb));
        check("cnt_a", 32'(dut_a.cnt), 32'(m % PA));
        check("cnt_b", 32'(dut_b.cnt), 32'(m % PB));
        for (int i = 0; i < 4; i++) begin
            hi_a[i] += int'(pwm_a[i]);
            hi_b[i] += int'(pwm_b[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);
        check("first_edge", 32'(pwm_a), 32'hF);
        for (int i = 0; i < 499; i++) step(1'b0);
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            hi_a[i] = 0;
            hi_b[i] = 0;
        end
        for (int i = 0; i < 480; i++) step(1'b0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("duty_a%0d", i), 32'(hi_a[i]), 32'(30 * DA[i]));
            check($sformatf("duty_b%0d", i), 32'(hi_b[i]), 32'(48 * DB[i]));
        end
        while (m % PA != 7) step(1'b0);
        step(1'b1);
        check("mid_reset", 32'(pwm_a), 32'h0);
        step(1'b0);
        check("restart", 32'(pwm_a), 32'hF);
        for (int i = 0; i < 2000; i++) step($urandom_range(19) == 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
Four-channel fixed-duty PWM generator. All channels share one free-running period counter and share phase. Each channel's high time is set at elaboration by a duty parameter. There are no data inputs: clk drives the block, and reset restarts every channel at the start of a period. It is a leaf block that feeds LEDs or motor drivers through pwm_out.

Parameters:
- PERIOD, 16, PWM period in clk cycles; legal range 2..65536.
- CNT_W, $clog2(PERIOD), counter width; derived, not for override.
- DUTY0, 4, channel 0 high cycles per period; legal range 0..PERIOD.
- DUTY1, 8, channel 1 high cycles per period; legal range 0..PERIOD.
- DUTY2, 12, channel 2 high cycles per period; legal range 0..PERIOD.
- DUTY3, 16, channel 3 high cycles per period; legal range 0..PERIOD.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high: 1 = reset, 0 = run. The legacy port name is kept and does not indicate polarity.
- pwm_out  output  4  registered PWM outputs; bit i is channel i.

Behaviour:
- Reset, sampled on a rising edge with rst_n=1:
  - cnt <= 0.
  - pwm_out <= 4'b0000.
  - Reset dominates all other updates.
  - Asserting reset mid-period takes effect on the next edge. The period then restarts from cnt=0 after release.
- Counter, every rising edge with rst_n=0:
  - cnt <= (cnt == PERIOD-1) ? 0 : cnt+1.
  - Values run 0..PERIOD-1 and wrap with no idle cycle.
  - No overflow past PERIOD-1, including non-power-of-two PERIOD.
- Outputs, same edge, using the pre-increment cnt:
  - pwm_out[i] <= (cnt < DUTYi).
  - Compare is unsigned, with DUTYi zero-extended to CNT_W+1 bits so that DUTYi = PERIOD is representable.
- Latency: pwm_out lags cnt by one register stage.
  - The first edge after reset release loads pwm_out[i] = (DUTYi > 0).
  - Channel i is high for exactly DUTYi consecutive cycles per PERIOD cycles, then low for PERIOD-DUTYi cycles.
  - Rising edges of all non-constant channels coincide, once per period.
- Boundary duties:
  - DUTYi = 0: channel constantly 0.
  - DUTYi = PERIOD: channel constantly 1 after the first post-reset edge.
  - DUTYi > PERIOD is illegal and must be flagged by an elaboration-time check (generate-time $error).
  - PERIOD < 2 is also illegal and flagged the same way.
- Glitch-free: every output comes directly from a flop, with no combinational path to pwm_out.
- Between edges, rst_n level changes have no effect (synchronous reset only).
- Duty cycle of channel i = DUTYi/PERIOD. Defaults give 25%, 50%, 75% and 100%.

Test Plan:
- Reset hold: rst_n=1 for 5 edges -> pwm_out=4'b0000 at every edge; cnt=0.
- Release, defaults: rst_n=0 -> first edge gives pwm_out=4'b1111. The first 4 cycles read 1111, cycles 4-7 read 1110, cycles 8-11 read 1100, cycles 12-15 read 1000, then the pattern repeats every 16 cycles for 500 cycles.
- Duty measurement: over 30 full periods, count high cycles per channel -> exactly 4/8/12/16 per 16-cycle period; ch3 never low after release.
- Edge cases: DUTY0=0, DUTY3=PERIOD, PERIOD=10 (non-power-of-two) -> ch0 always 0, ch3 always 1, cnt wraps 9->0, all periods exactly 10 cycles.
- Mid-period reset: assert rst_n=1 at cnt=7 for 1 edge, then release -> pwm_out=0000 on that edge. The next edge restarts the period with pwm_out=1111 and full-length periods thereafter.
- Illegal parameter: DUTY1=PERIOD+1 -> elaboration fails with error.
